// File: rtl/serial_alu_32_if.sv
// Request/response bundle for the bit-serial ALU: operands and opcode in,
// status flags and registered result out.
interface serial_alu_32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/serial_alu_32.sv
// Bit-serial ALU: one result bit per clock, LSB first, through 1-bit
// AND/OR/XOR/full-adder cells; result and flags update only on completion.
module serial_alu_32 #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  serial_alu_32_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic [1:0]       op_r;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;

  logic             bit_c;
  logic             cy_c;
  logic [WIDTH-1:0] part_c;

  // One-bit cell; carry stays 0 for the logic ops.
  always_comb begin
    bit_c = 1'b0;
    cy_c  = 1'b0;
    case (op_r)
      2'b00: bit_c = a_sh[0] & b_sh[0];
      2'b01: bit_c = a_sh[0] | b_sh[0];
      2'b10: bit_c = a_sh[0] ^ b_sh[0];
      2'b11: begin
        bit_c = a_sh[0] ^ b_sh[0] ^ cy;
        cy_c  = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);
      end
    endcase
    part_c = {bit_c, part[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      part     <= '0;
      op_r     <= 2'b00;
      cy       <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            op_r   <= bus.op;
            cy     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          part <= part_c;
          cy   <= cy_c;
          cnt  <= cnt + CW'(1);
          // Last bit: publish the completed word together with its flags.
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= part_c;
            carry_q  <= cy_c;
            zero_q   <= (part_c == '0);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_alu_32.sv
// Scoreboard bench for serial_alu_32: table vectors, random ops and
// hand-written sequences for re-start, reset-abort and reset/start collisions.
module tb_serial_alu_32;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_alu_32_if #(.WIDTH(W)) bus ();
  serial_alu_32 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } vec_t;

  exp_t         sbq[$];
  vec_t         tbl[11];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] held_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    e.c = 1'b0;
    case (op)
      2'b00: e.r = a & b;
      2'b01: e.r = a | b;
      2'b10: e.r = a ^ b;
      default: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        e = sbq.pop_front();
        check("result", 64'(bus.result), 64'(e.r));
        check("carry_out", 64'(bus.carry_out), 64'(e.c));
        check("zero", 64'(bus.zero), 64'(e.z));
      end
    end
  end

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) fail_now("wait_done");
  endtask

  // Drive one operation, scramble the inputs after acceptance, count busy cycles.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
    int busy_n = 0;
    bit got    = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sbq.push_back(e);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = a;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (i == 5) check("hold_during_run", 64'(bus.result), 64'(held_r));
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) fail_now("run_op_done");
    check("busy_cycles", 64'(busy_n), 64'(W));
    held_r = e.r;
  endtask

  initial begin
    exp_t e;
    exp_t e2;

    tbl[0]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    tbl[1]  = '{2'b00, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1};
    tbl[3]  = '{2'b01, 32'h00000001, 32'h80000000, 32'h80000001, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tbl[6]  = '{2'b11, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    tbl[8]  = '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    tbl[9]  = '{2'b10, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_carry", 64'(bus.carry_out), 64'(0));
    check("rst_zero", 64'(bus.zero), 64'(1));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      e.r = tbl[i].r;
      e.c = tbl[i].c;
      e.z = tbl[i].z;
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      run_op(op, a, b, model(op, a, b));
    end

    // Re-start at edge N+5 is ignored; start held through DONE is taken only after it.
    e = model(2'b11, 32'h0F0F0F0F, 32'h01010101);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'h0F0F0F0F;
    bus.b     = 32'h01010101;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    e2 = model(2'b10, 32'hDEADBEEF, 32'h0000FFFF);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h0000FFFF;
    sbq.push_back(e2);
    @(negedge clk);
    check("start_in_done_ignored", 64'(bus.busy), 64'(0));
    @(negedge clk);
    check("start_after_done_taken", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    wait_done();
    held_r = e2.r;

    // Reset at edge N+10 of an ADD aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'h11111111;
    bus.b     = 32'h22222222;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_abort", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_zero", 64'(bus.zero), 64'(1));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_result_after", 64'(bus.result), 64'(0));
    held_r = '0;

    // Reset wins over start at the same edge.
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 64'(bus.busy), 64'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", 64'(bus.busy), 64'(0));

    e.r = 32'h00000003;
    e.c = 1'b0;
    e.z = 1'b0;
    run_op(2'b11, 32'h1, 32'h2, e);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
